// File: rtl/uart_pkg.sv
// uart_pkg: types and constants shared by the UART receive and transmit engines.
package uart_pkg;

   localparam int UART_DATA_BITS = 8;

   // Frame engine states; PARITY is only reachable when parity is built in.
   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } uart_rx_state_t;

   // Even parity over a data byte: the parity bit that makes the total count of ones even.
   function automatic logic even_parity(input logic [UART_DATA_BITS-1:0] d);
      return ^d;
   endfunction

endpackage

// File: rtl/uart_sync2.sv
// uart_sync2: two-flop synchronizer for an asynchronous single-bit input.
// RST_VAL sets the level both flops take during reset, so an idle-high line
// does not look like an edge coming out of reset.
module uart_sync2 #(
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic d_i,
   output logic q_o
);

   logic meta_q;
   logic sync_q;

   // Two back-to-back flops; only sync_q is used downstream.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         meta_q <= RST_VAL;
         sync_q <= RST_VAL;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/uart_rx_frame.sv
// uart_rx_frame: UART receive engine, mid-bit sampling with a fixed divisor.
// Default build receives 8N1 frames. Defining UART_RX_PARITY_EN adds an
// even-parity bit after the data (8E1); a parity mismatch is reported on err_o.
// Handshake: done_o is a one-cycle strobe with no back-pressure; data_out_o and
// err_o are valid in the cycle done_o is high, data_out_o then holds.
module uart_rx_frame
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 434
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic                      rx_en_i,
   input  logic                      data_in_i,
   output logic [UART_DATA_BITS-1:0] data_out_o,
   output logic                      done_o,
   output logic                      err_o,
   output logic                      busy_o,
   output uart_rx_state_t            state_o
);

   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

   logic                      rx_s;
   uart_rx_state_t            state_q;
   logic [CNT_W-1:0]          cnt_q;
   logic [2:0]                bit_q;
   logic [UART_DATA_BITS-1:0] shift_q;
   logic [UART_DATA_BITS-1:0] shift_d;
   logic [UART_DATA_BITS-1:0] data_q;
   logic                      done_q;
   logic                      err_q;
   logic                      armed_q;
   logic                      frame_err_d;
`ifdef UART_RX_PARITY_EN
   logic                      par_err_q;
   logic                      par_err_d;
`endif

   uart_sync2 #(
      .RST_VAL (1'b1)
   ) u_sync (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .d_i   (data_in_i),
      .q_o   (rx_s)
   );

   // Next shift value (LSB first on the wire) and per-sample error terms.
   always_comb begin
      shift_d     = {rx_s, shift_q[UART_DATA_BITS-1:1]};
      frame_err_d = ~rx_s;
`ifdef UART_RX_PARITY_EN
      par_err_d   = rx_s ^ even_parity(shift_q);
`endif
   end

   // Frame FSM with its counters, shift register and registered outputs.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         bit_q     <= '0;
         shift_q   <= '0;
         data_q    <= '0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
         armed_q   <= 1'b1;
`ifdef UART_RX_PARITY_EN
         par_err_q <= 1'b0;
`endif
      end else begin
         done_q <= 1'b0;
         err_q  <= 1'b0;
         // A high line re-arms start detection after a break.
         if (rx_s) armed_q <= 1'b1;
         if (!rx_en_i) begin
            state_q <= IDLE;
         end else begin
            case (state_q)
               IDLE: begin
                  if (!rx_s && armed_q) begin
                     state_q <= START;
                     cnt_q   <= '0;
                     bit_q   <= '0;
                  end
               end
               START: begin
                  if (cnt_q == HALF_M1) begin
                     cnt_q   <= '0;
                     // Line back high at mid start bit means a glitch.
                     state_q <= rx_s ? IDLE : DATA;
                  end else begin
                     cnt_q <= cnt_q + CNT_W'(1);
                  end
               end
               DATA: begin
                  if (cnt_q == FULL_M1) begin
                     cnt_q   <= '0;
                     shift_q <= shift_d;
                     bit_q   <= bit_q + 3'd1;
                     if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_q <= PARITY;
`else
                        state_q <= STOP;
`endif
                     end
                  end else begin
                     cnt_q <= cnt_q + CNT_W'(1);
                  end
               end
`ifdef UART_RX_PARITY_EN
               PARITY: begin
                  if (cnt_q == FULL_M1) begin
                     cnt_q     <= '0;
                     par_err_q <= par_err_d;
                     state_q   <= STOP;
                  end else begin
                     cnt_q <= cnt_q + CNT_W'(1);
                  end
               end
`endif
               STOP: begin
                  if (cnt_q == FULL_M1) begin
                     cnt_q   <= '0;
                     data_q  <= shift_q;
                     done_q  <= 1'b1;
`ifdef UART_RX_PARITY_EN
                     err_q   <= frame_err_d | par_err_q;
`else
                     err_q   <= frame_err_d;
`endif
                     // A low stop bit may be a break; wait for the line to go high.
                     armed_q <= rx_s;
                     state_q <= IDLE;
                  end else begin
                     cnt_q <= cnt_q + CNT_W'(1);
                  end
               end
               default: state_q <= IDLE;
            endcase
         end
      end
   end

   assign data_out_o = data_q;
   assign done_o     = done_q;
   assign err_o      = err_q;
   assign busy_o     = (state_q != IDLE);
   assign state_o    = state_q;

endmodule

// File: tb/tb_uart_rx_frame.sv
// tb_uart_rx_frame: directed bench for uart_rx_frame with CLKS_PER_BIT = 16.
// Works in both builds; the parity frames are exercised when UART_RX_PARITY_EN is defined.
module tb_uart_rx_frame;
   import uart_pkg::*;

   localparam int N = 16;
   localparam int H = N / 2;
`ifdef UART_RX_PARITY_EN
   localparam bit PAR_EN = 1'b1;
   localparam int LAT    = 2 + H + 10 * N;
`else
   localparam bit PAR_EN = 1'b0;
   localparam int LAT    = 2 + H + 9 * N;
`endif

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic           rx_en = 1'b0;
   logic           data_in = 1'b1;
   logic [7:0]     data_out;
   logic           done;
   logic           err;
   logic           busy;
   uart_rx_state_t state;

   int total = 0;
   int bad   = 0;

   uart_rx_frame #(
      .CLKS_PER_BIT (N)
   ) dut (
      .clk_i      (clk),
      .rst_i      (rst),
      .rx_en_i    (rx_en),
      .data_in_i  (data_in),
      .data_out_o (data_out),
      .done_o     (done),
      .err_o      (err),
      .busy_o     (busy),
      .state_o    (state)
   );

   // Clock and cycle index (cyc = number of rising edges so far).
   always #5 clk = ~clk;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Output monitor on the falling edge: counts done pulses and latches what came with them.
   int         done_cnt  = 0;
   int         done_cyc  = 0;
   logic [7:0] last_data = 8'h00;
   logic       last_err  = 1'b0;
   bit         busy_seen = 1'b0;
   always @(negedge clk) begin
      if (done) begin
         done_cnt  = done_cnt + 1;
         done_cyc  = cyc;
         last_data = data_out;
         last_err  = err;
      end
      if (busy) busy_seen = 1'b1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total = total + 1;
      assert (obs === exp) else begin
         bad = bad + 1;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Called and returns at posedge+1.
   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   int start_cyc = 0;

   // Drives start, 8 data bits LSB first, optional parity, stop; each bit N clocks.
   // Stops early after max_cyc clocks. Leaves the line at its last driven level.
   task automatic drive_frame(input logic [7:0] d, input logic par, input logic stp, input int max_cyc);
      logic bits[$];
      int   n;
      bits.push_back(1'b0);
      for (int i = 0; i < 8; i++) bits.push_back(d[i]);
      if (PAR_EN) bits.push_back(par);
      bits.push_back(stp);
      n = 0;
      start_cyc = cyc;
      foreach (bits[b]) begin
         for (int c = 0; c < N; c++) begin
            if (n == max_cyc) return;
            data_in = bits[b];
            @(posedge clk);
            #1;
            n++;
         end
      end
   endtask

   initial begin
      // Reset state
      idle(3);
      chk("rst_data", 32'(data_out), 32'h00);
      chk("rst_done", 32'(done), 32'h0);
      chk("rst_err", 32'(err), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_state", 32'(state), 32'(IDLE));
      rst = 1'b0;
      rx_en = 1'b1;
      idle(5);

      // 0x55 clean frame, latency from the first edge that sees the low line
      drive_frame(8'h55, 1'b0, 1'b1, 1000);
      data_in = 1'b1;
      idle(2 * N);
      chk("t55_lat", 32'(done_cyc - start_cyc - 1), 32'(LAT));
      chk("t55_cnt", 32'(done_cnt), 32'd1);
      chk("t55_data", 32'(last_data), 32'h55);
      chk("t55_err", 32'(last_err), 32'h0);
      chk("t55_hold", 32'(data_out), 32'h55);
      chk("t55_busy", 32'(busy), 32'h0);

      // 0xA3 with a low stop bit, then a 40-clock break
      drive_frame(8'hA3, 1'b0, 1'b0, 1000);
      data_in = 1'b0;
      idle(40);
      chk("ta3_cnt", 32'(done_cnt), 32'd2);
      chk("ta3_data", 32'(last_data), 32'hA3);
      chk("ta3_err", 32'(last_err), 32'h1);
      chk("brk_busy", 32'(busy), 32'h0);
      chk("brk_state", 32'(state), 32'(IDLE));
      data_in = 1'b1;
      idle(N);
      drive_frame(8'h0F, 1'b0, 1'b1, 1000);
      data_in = 1'b1;
      idle(2 * N);
      chk("t0f_cnt", 32'(done_cnt), 32'd3);
      chk("t0f_data", 32'(last_data), 32'h0F);
      chk("t0f_err", 32'(last_err), 32'h0);

      // 3-clock glitch on an idle line
      busy_seen = 1'b0;
      data_in = 1'b0;
      idle(3);
      data_in = 1'b1;
      idle(2 + H + 3);
      chk("glt_busy", 32'(busy), 32'h0);
      chk("glt_seen", 32'(busy_seen), 32'h1);
      idle(12 * N);
      chk("glt_cnt", 32'(done_cnt), 32'd3);

      // rx_en dropped during data bit 4 of 0xFF
      drive_frame(8'hFF, 1'b0, 1'b1, 5 * N + 5);
      rx_en = 1'b0;
      data_in = 1'b1;
      idle(3);
      chk("en_busy", 32'(busy), 32'h0);
      rx_en = 1'b1;
      idle(12 * N);
      chk("en_cnt", 32'(done_cnt), 32'd3);
      chk("en_hold", 32'(data_out), 32'h0F);
      drive_frame(8'h81, 1'b0, 1'b1, 1000);
      data_in = 1'b1;
      idle(2 * N);
      chk("t81_cnt", 32'(done_cnt), 32'd4);
      chk("t81_data", 32'(last_data), 32'h81);
      chk("t81_err", 32'(last_err), 32'h0);

      // Asynchronous reset in the middle of a frame
      drive_frame(8'h3C, 1'b0, 1'b1, 80);
      rst = 1'b1;
      #1;
      chk("arst_data", 32'(data_out), 32'h00);
      chk("arst_done", 32'(done), 32'h0);
      chk("arst_err", 32'(err), 32'h0);
      chk("arst_busy", 32'(busy), 32'h0);
      chk("arst_state", 32'(state), 32'(IDLE));
      data_in = 1'b1;
      @(posedge clk);
      #1;
      idle(2);
      rst = 1'b0;
      idle(N);
      chk("arst_cnt", 32'(done_cnt), 32'd4);
      drive_frame(8'h3C, 1'b0, 1'b1, 1000);
      data_in = 1'b1;
      idle(2 * N);
      chk("t3c_cnt", 32'(done_cnt), 32'd5);
      chk("t3c_data", 32'(last_data), 32'h3C);
      chk("t3c_err", 32'(last_err), 32'h0);

`ifdef UART_RX_PARITY_EN
      // 0x07 has three ones: even parity bit is 1
      drive_frame(8'h07, 1'b1, 1'b1, 1000);
      data_in = 1'b1;
      idle(2 * N);
      chk("p07_cnt", 32'(done_cnt), 32'd6);
      chk("p07_data", 32'(last_data), 32'h07);
      chk("p07_err", 32'(last_err), 32'h0);
      drive_frame(8'h07, 1'b0, 1'b1, 1000);
      data_in = 1'b1;
      idle(2 * N);
      chk("p07b_cnt", 32'(done_cnt), 32'd7);
      chk("p07b_data", 32'(last_data), 32'h07);
      chk("p07b_err", 32'(last_err), 32'h1);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/uart_rx_frame.md
# uart_rx_frame

Serial-to-parallel UART receive engine for the memory-mapped UART peripheral. It sits between the external `data_in_rx` pin and the UART register file. It recovers 8N1 frames (optionally 8E1) by mid-bit sampling with a fixed clocks-per-bit divisor. Each frame is presented as a byte plus a one-cycle `done` strobe and an `err` flag, which feed the RX-data and status registers.

## Interface
- `CLKS_PER_BIT`, default 434: system clocks per bit period (50 MHz / 115200). Must be ≥ 4.
- `clk`  input  1  system clock; all logic on rising edge.
- `rst`  input  1  asynchronous, active-high reset.
- `rx_en`  input  1  receiver enable; low forces IDLE.
- `data_in`  input  1  asynchronous serial line; idles high.
- `data_out`  output  8  last received byte, LSB first on the wire; holds until the next completed frame.
- `done`  output  1  one-cycle pulse per completed frame.
- `err`  output  1  framing or parity error for the frame; valid only while `done`=1, otherwise 0.
- `busy`  output  1  high in any state other than IDLE.

## Operation
- `data_in` is passed through a 2-flop synchronizer, reset value 1. All decisions use the synchronized value `rx_s`.
- States: IDLE, START, DATA, PARITY (only when the macro is defined), STOP.
- IDLE → START when `rx_en`=1 and `rx_s`=0. The bit counter and clock counter clear.
- START: wait `CLKS_PER_BIT/2` clocks (integer division).
  - If `rx_s`=1 at that point, it was a glitch: return to IDLE with no `done`.
  - If `rx_s`=0, enter DATA with the clock counter cleared.
- DATA: sample `rx_s` every `CLKS_PER_BIT` clocks into the shift register, LSB first.
  - The bit index runs 0–7.
  - After bit 7, go to PARITY if enabled, otherwise STOP.
- PARITY: sample one bit after `CLKS_PER_BIT`. Error if it differs from the XOR of the 8 data bits (even parity).
- STOP: sample after `CLKS_PER_BIT`.
  - `rx_s`=0 is a framing error.
  - In the same cycle, load `data_out`, pulse `done`, drive `err` = framing error OR parity error, and go to IDLE.
- A byte with an error is still loaded into `data_out`.
- `rx_en` falling in any non-IDLE state: return to IDLE next cycle. No `done`, `data_out` unchanged.
- A line held low after STOP (break) does not start a new frame until `rx_s` returns to 1 and falls again. The IDLE entry requires a prior high level, tracked by an `armed` flag.
- Counter widths are `$clog2(CLKS_PER_BIT)` bits; the clock counter wraps to 0 on each sample.

## Timing
- Reset values: `data_out`=0x00, `done`=0, `err`=0, `busy`=0, state IDLE, synchronizer flops=1, `armed`=1.
- Sample points are relative to the first `rx_s`=0 cycle, with H = `CLKS_PER_BIT/2` and N = `CLKS_PER_BIT`:
  - start check at +H
  - data bit k at +H + (k+1)·N
  - stop at +H + 9·N, or +H + 10·N with parity.
- `done`, `err` and `data_out` update on the clock edge of the stop sample, so they are visible the following cycle.
- Pin-to-`done` latency: 2 (synchronizer) + H + 9·N clocks (10·N with parity).
- `busy` rises the cycle after the START entry and falls together with the `done` pulse.
- Asynchronous reset mid-frame: everything returns to reset values immediately, with no `done`.

## Configuration
- `UART_RX_PARITY_EN` defined: 8E1 frames. PARITY state present; a parity mismatch sets `err` on `done`.
- Undefined: 8N1 frames. The PARITY state and parity logic are absent, and `err` reflects the framing error only.

## Structure
- Shared package `uart_pkg` holds:
  - the state enum `uart_rx_state_t` (IDLE, START, DATA, PARITY, STOP), shared with the future transmitter
  - the `UART_DATA_BITS`=8 constant.
- Sub-module `uart_sync2`: generic 2-flop synchronizer with a parameterized reset value, reused for GPIO inputs.
- Top-level `uart_rx_frame` contains the FSM, counters, shift register and output registers.

## Test plan
- With `CLKS_PER_BIT`=16, send 0x55 8N1 → `done` pulses once at 2+8+144 clocks from the start edge; `data_out`=0x55, `err`=0.
- Send 0xA3 with the stop bit driven 0 → `done`=1, `data_out`=0xA3, `err`=1. Then hold the line low for 40 clocks, release it and send 0x0F → exactly one further `done` with 0x0F.
- Drive a 3-clock low glitch on idle → no `done`; `busy` returns to 0 within H+3 cycles.
- Deassert `rx_en` during data bit 4 of 0xFF → no `done`, `data_out` keeps its previous value. A subsequent 0x81 is received correctly.
- Assert `rst` mid-frame → all outputs are at reset values in the same cycle. Send 0x3C after release → received correctly.
- With `UART_RX_PARITY_EN`:
  - 0x07 with parity bit 1 → `err`=0.
  - Same frame with parity bit 0 → `err`=1, `data_out`=0x07.
